// File: rtl/harv_dmem_wb_bridge_pkg.sv
// Shared types and lane helpers for the harv data-memory to Wishbone bridge.
// Access size decoding, alignment checking, and sub-word extract/merge all
// live here so the FSM and the lane unit agree on lane numbering.
package harv_dmem_bridge_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // The reserved encoding 3 behaves as a word access.
    function automatic size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'd0:    decode_size = SIZE_BYTE;
            2'd1:    decode_size = SIZE_HALF;
            default: decode_size = SIZE_WORD;
        endcase
    endfunction

    // Bytes are never misaligned; halves need addr[0]=0, words addr[1:0]=0.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SIZE_HALF: is_misaligned = addr_lo[0];
            SIZE_WORD: is_misaligned = |addr_lo;
            default:   is_misaligned = 1'b0;
        endcase
    endfunction

    // Pull the addressed lane out of a bus word and extend it to 32 bits.
    // Word loads ignore usgn.
    function automatic logic [31:0] extract_lane(input logic [31:0] word, input size_e size,
                                                 input logic [1:0] addr_lo, input logic usgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{addr_lo, 3'b000} +: 8];
        h = word[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SIZE_BYTE: extract_lane = {{24{b[7] & ~usgn}}, b};
            SIZE_HALF: extract_lane = {{16{h[15] & ~usgn}}, h};
            default:   extract_lane = word;
        endcase
    endfunction

    // Overwrite the addressed lane of the old word with the low bits of wdata.
    function automatic logic [31:0] merge_lane(input logic [31:0] old_word, input logic [31:0] wdata,
                                               input size_e size, input logic [1:0] addr_lo);
        logic [31:0] r;
        r = old_word;
        case (size)
            SIZE_BYTE: r[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            SIZE_HALF: r[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default:   r = wdata;
        endcase
        merge_lane = r;
    endfunction

endpackage

// File: rtl/harv_dmem_wb_bridge_if.sv
// Interfaces for the bridge: the core's req/gnt data port (core = master,
// bridge = slave) and the word-only classic Wishbone data bus
// (bridge = master, memory controller = slave).
interface harv_dmem_if;
    logic        dmem_req_i;
    logic        dmem_wren_i;
    logic [1:0]  dmem_size_i;
    logic        dmem_usgn_i;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_wdata_i;
    logic        dmem_gnt_o;
    logic        dmem_err_o;
    logic [31:0] dmem_rdata_o;

    modport master (
        output dmem_req_i, dmem_wren_i, dmem_size_i, dmem_usgn_i, dmem_addr_i, dmem_wdata_i,
        input  dmem_gnt_o, dmem_err_o, dmem_rdata_o
    );
    modport slave (
        input  dmem_req_i, dmem_wren_i, dmem_size_i, dmem_usgn_i, dmem_addr_i, dmem_wdata_i,
        output dmem_gnt_o, dmem_err_o, dmem_rdata_o
    );
endinterface

interface harv_wb_if;
    logic        data_mem_cyc_o;
    logic        data_mem_stb_o;
    logic        data_mem_we_o;
    logic [31:0] data_mem_addr_o;
    logic [31:0] data_mem_data_o;
    logic [31:0] data_mem_data_i;
    logic        data_mem_ack_i;

    modport master (
        output data_mem_cyc_o, data_mem_stb_o, data_mem_we_o, data_mem_addr_o, data_mem_data_o,
        input  data_mem_data_i, data_mem_ack_i
    );
    modport slave (
        input  data_mem_cyc_o, data_mem_stb_o, data_mem_we_o, data_mem_addr_o, data_mem_data_o,
        output data_mem_data_i, data_mem_ack_i
    );
endinterface

// File: rtl/harv_dmem_wb_bridge_lane.sv
// Combinational lane unit: extracts/extends load data from the live bus word
// and builds the merged store word for read-modify-write.
module harv_dmem_lane_unit
    import harv_dmem_bridge_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  size_e       size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        usgn_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);
    assign load_data_o  = extract_lane(rd_word_i, size_i, addr_lo_i, usgn_i);
    assign merge_data_o = merge_lane(old_word_i, wdata_i, size_i, addr_lo_i);
endmodule

// File: rtl/harv_dmem_wb_bridge.sv
// harv data-memory port to word-only Wishbone bridge.
// Sub-word stores are done as read-modify-write (READ -> MERGE -> WRITE).
// Optional: define HARV_DMEM_BRIDGE_TIMEOUT_EN to abort bus cycles that see
// no ack within TIMEOUT_CYCLES cycles (err=1, rdata=0, an RMW never writes).
module harv_dmem_wb_bridge
    import harv_dmem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_core,
    input  logic       rst_core,
    harv_dmem_if.slave dmem,
    harv_wb_if.master  wb
);
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e      state_q;
    size_e       size_q;
    logic        wren_q;
    logic        usgn_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic [31:0] rword_q;
    logic        gnt_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        cyc_q;
    logic        we_q;
    logic [31:0] baddr_q;
    logic [31:0] bdata_q;
`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
    logic [31:0] tmo_q;
`endif

    logic [31:0] load_data;
    logic [31:0] merge_data;
    size_e       req_size;

    assign req_size = decode_size(dmem.dmem_size_i);

    harv_dmem_lane_unit u_lane (
        .rd_word_i   (wb.data_mem_data_i),
        .old_word_i  (rword_q),
        .wdata_i     (wdata_q),
        .size_i      (size_q),
        .addr_lo_i   (addr_lo_q),
        .usgn_i      (usgn_q),
        .load_data_o (load_data),
        .merge_data_o(merge_data)
    );

    // Bridge FSM: all outputs are registered and set on the transition into a state.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state_q   <= ST_IDLE;
            size_q    <= SIZE_BYTE;
            wren_q    <= 1'b0;
            usgn_q    <= 1'b0;
            addr_lo_q <= 2'b00;
            wdata_q   <= '0;
            rword_q   <= '0;
            gnt_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            baddr_q   <= '0;
            bdata_q   <= '0;
`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            gnt_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dmem.dmem_req_i) begin
                        size_q    <= req_size;
                        wren_q    <= dmem.dmem_wren_i;
                        usgn_q    <= dmem.dmem_usgn_i;
                        addr_lo_q <= dmem.dmem_addr_i[1:0];
                        wdata_q   <= dmem.dmem_wdata_i;
                        rdata_q   <= '0;
                        err_q     <= 1'b0;
`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
                        tmo_q     <= '0;
`endif
                        if (is_misaligned(req_size, dmem.dmem_addr_i[1:0])) begin
                            state_q <= ST_RESP;
                            gnt_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (dmem.dmem_wren_i && req_size == SIZE_WORD) begin
                            state_q <= ST_WRITE;
                            cyc_q   <= 1'b1;
                            we_q    <= 1'b1;
                            baddr_q <= {dmem.dmem_addr_i[31:2], 2'b00};
                            bdata_q <= dmem.dmem_wdata_i;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            state_q <= ST_READ;
                            cyc_q   <= 1'b1;
                            we_q    <= 1'b0;
                            baddr_q <= {dmem.dmem_addr_i[31:2], 2'b00};
                        end
                    end
                end
                ST_READ: begin
                    if (wb.data_mem_ack_i) begin
                        cyc_q <= 1'b0;
                        if (wren_q) begin
                            // Keep the address: the write-back goes to the same word.
                            rword_q <= wb.data_mem_data_i;
                            state_q <= ST_MERGE;
                        end else begin
                            rdata_q <= load_data;
                            baddr_q <= '0;
                            state_q <= ST_RESP;
                            gnt_q   <= 1'b1;
                        end
`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
                    end else if (tmo_q == TIMEOUT_CYCLES - 1) begin
                        cyc_q   <= 1'b0;
                        baddr_q <= '0;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                        gnt_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
`endif
                    end
                end
                ST_MERGE: begin
                    bdata_q <= merge_data;
                    cyc_q   <= 1'b1;
                    we_q    <= 1'b1;
                    state_q <= ST_WRITE;
`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                end
                ST_WRITE: begin
                    if (wb.data_mem_ack_i) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        baddr_q <= '0;
                        bdata_q <= '0;
                        state_q <= ST_RESP;
                        gnt_q   <= 1'b1;
`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
                    end else if (tmo_q == TIMEOUT_CYCLES - 1) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        baddr_q <= '0;
                        bdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                        gnt_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
`endif
                    end
                end
                ST_RESP: begin
                    // gnt was raised on entry; requests seen here are ignored.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cyc_q   <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign dmem.dmem_gnt_o   = gnt_q;
    assign dmem.dmem_err_o   = err_q;
    assign dmem.dmem_rdata_o = rdata_q;
    assign wb.data_mem_cyc_o  = cyc_q;
    assign wb.data_mem_stb_o  = cyc_q;
    assign wb.data_mem_we_o   = we_q;
    assign wb.data_mem_addr_o = baddr_q;
    assign wb.data_mem_data_o = bdata_q;

endmodule

// File: tb/tb_harv_dmem_wb_bridge.sv
// Directed bench for harv_dmem_wb_bridge with a behavioural Wishbone slave.
module tb_harv_dmem_wb_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 1024;
`endif

    harv_dmem_if dmem_bus ();
    harv_wb_if   wb_bus ();

    harv_dmem_wb_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_core(clk),
        .rst_core(rst),
        .dmem    (dmem_bus),
        .wb      (wb_bus)
    );

    // Slave: fixed read word, ack after 'waits' wait states, optional stray ack.
    logic [31:0] mem_word = '0;
    int          waits = 0;
    int          wcnt = 0;
    logic        force_ack = 1'b0;

    assign wb_bus.data_mem_data_i = mem_word;
    assign wb_bus.data_mem_ack_i  = force_ack | (wb_bus.data_mem_cyc_o && (wcnt == waits));

    always @(posedge clk) begin
        if (wb_bus.data_mem_cyc_o && !wb_bus.data_mem_ack_i) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    // Bus monitor: counts cycles and acked transfers, flags instability within a cycle.
    int          rd_cnt = 0, wr_cnt = 0, cyc_cnt = 0, unstable_cnt = 0;
    logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0;
    logic [31:0] hold_addr = '0, hold_data = '0;
    logic        hold_we = 1'b0, prev_cyc = 1'b0;

    always @(negedge clk) begin
        if (wb_bus.data_mem_stb_o !== wb_bus.data_mem_cyc_o) unstable_cnt = unstable_cnt + 1;
        if (wb_bus.data_mem_cyc_o === 1'b1) begin
            cyc_cnt = cyc_cnt + 1;
            if (prev_cyc && (wb_bus.data_mem_addr_o !== hold_addr ||
                             wb_bus.data_mem_data_o !== hold_data ||
                             wb_bus.data_mem_we_o !== hold_we))
                unstable_cnt = unstable_cnt + 1;
            hold_addr = wb_bus.data_mem_addr_o;
            hold_data = wb_bus.data_mem_data_o;
            hold_we   = wb_bus.data_mem_we_o;
            if (wb_bus.data_mem_ack_i) begin
                if (wb_bus.data_mem_we_o) begin
                    wr_cnt  = wr_cnt + 1;
                    wr_addr = wb_bus.data_mem_addr_o;
                    wr_data = wb_bus.data_mem_data_o;
                end else begin
                    rd_cnt  = rd_cnt + 1;
                    rd_addr = wb_bus.data_mem_addr_o;
                end
            end
        end
        prev_cyc = (wb_bus.data_mem_cyc_o === 1'b1);
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rd_cnt  = 0;
        wr_cnt  = 0;
        cyc_cnt = 0;
    endtask

    // Issue one request, hold it until gnt (bounded), then drop it.
    // lat = cycles from the req-sample edge to gnt (0 if gnt never came).
    task automatic run_req(input string tag, input logic wren, input logic [1:0] size,
                           input logic usgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input int max_cyc, output int lat,
                           output logic [31:0] rdata, output logic err);
        clear_mon();
        dmem_bus.dmem_wren_i  = wren;
        dmem_bus.dmem_size_i  = size;
        dmem_bus.dmem_usgn_i  = usgn;
        dmem_bus.dmem_addr_i  = addr;
        dmem_bus.dmem_wdata_i = wdata;
        dmem_bus.dmem_req_i   = 1'b1;
        lat   = 0;
        rdata = '0;
        err   = 1'b0;
        for (int n = 1; n <= max_cyc; n++) begin
            @(posedge clk); #1;
            if (dmem_bus.dmem_gnt_o === 1'b1) begin
                lat   = n;
                rdata = dmem_bus.dmem_rdata_o;
                err   = dmem_bus.dmem_err_o;
                break;
            end
        end
        dmem_bus.dmem_req_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_gnt_pulse"}, {31'd0, dmem_bus.dmem_gnt_o}, 32'd0);
        $display("txn %s: addr=%08h wren=%0b size=%0d lat=%0d rdata=%08h err=%0b",
                 tag, addr, wren, size, lat, rdata, err);
    endtask

    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        seen;

    initial begin
        dmem_bus.dmem_req_i   = 1'b0;
        dmem_bus.dmem_wren_i  = 1'b0;
        dmem_bus.dmem_size_i  = 2'd0;
        dmem_bus.dmem_usgn_i  = 1'b0;
        dmem_bus.dmem_addr_i  = '0;
        dmem_bus.dmem_wdata_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt",   {31'd0, dmem_bus.dmem_gnt_o}, 32'd0);
        chk("rst_err",   {31'd0, dmem_bus.dmem_err_o}, 32'd0);
        chk("rst_rdata", dmem_bus.dmem_rdata_o, 32'd0);
        chk("rst_cyc",   {31'd0, wb_bus.data_mem_cyc_o}, 32'd0);
        chk("rst_stb",   {31'd0, wb_bus.data_mem_stb_o}, 32'd0);
        chk("rst_we",    {31'd0, wb_bus.data_mem_we_o}, 32'd0);
        chk("rst_addr",  wb_bus.data_mem_addr_o, 32'd0);
        chk("rst_data",  wb_bus.data_mem_data_o, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Signed byte load, zero-wait
        mem_word = 32'h80FF_1234; waits = 0;
        run_req("ld_b_s", 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 20, lat, rdata, err);
        chk("ld_b_s_lat", lat, 32'd2);
        chk("ld_b_s_rdata", rdata, 32'hFFFF_FF80);
        chk("ld_b_s_err", {31'd0, err}, 32'd0);
        chk("ld_b_s_rdcnt", rd_cnt, 32'd1);
        chk("ld_b_s_rdaddr", rd_addr, 32'h0000_0100);
        chk("ld_b_s_wrcnt", wr_cnt, 32'd0);

        // Unsigned half load, 3 wait states
        mem_word = 32'hBEEF_0000; waits = 3;
        run_req("ld_h_u", 1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'h0, 20, lat, rdata, err);
        chk("ld_h_u_lat", lat, 32'd5);
        chk("ld_h_u_rdata", rdata, 32'h0000_BEEF);
        chk("ld_h_u_cyccnt", cyc_cnt, 32'd4);
        chk("ld_h_u_rdaddr", rd_addr, 32'h0000_0200);

        // More lane/extension patterns
        waits = 0;
        mem_word = 32'h1234_8001;
        run_req("ld_h_s", 1'b0, 2'd1, 1'b0, 32'h0000_0000, 32'h0, 20, lat, rdata, err);
        chk("ld_h_s_rdata", rdata, 32'hFFFF_8001);
        mem_word = 32'h00AB_0000;
        run_req("ld_b_u", 1'b0, 2'd0, 1'b1, 32'h0000_0002, 32'h0, 20, lat, rdata, err);
        chk("ld_b_u_rdata", rdata, 32'h0000_00AB);
        run_req("ld_b_s2", 1'b0, 2'd0, 1'b0, 32'h0000_0002, 32'h0, 20, lat, rdata, err);
        chk("ld_b_s2_rdata", rdata, 32'hFFFF_FFAB);
        mem_word = 32'h8000_0001;
        run_req("ld_w", 1'b0, 2'd2, 1'b1, 32'h0000_0008, 32'h0, 20, lat, rdata, err);
        chk("ld_w_rdata", rdata, 32'h8000_0001);
        chk("ld_w_lat", lat, 32'd2);
        mem_word = 32'h7654_3210;
        run_req("ld_rsv", 1'b0, 2'd3, 1'b0, 32'h0000_000C, 32'h0, 20, lat, rdata, err);
        chk("ld_rsv_rdata", rdata, 32'h7654_3210);

        // Byte store via RMW
        mem_word = 32'h1122_3344; waits = 0;
        run_req("st_b", 1'b1, 2'd0, 1'b0, 32'h0000_0301, 32'h1234_56AA, 20, lat, rdata, err);
        chk("st_b_lat", lat, 32'd4);
        chk("st_b_err", {31'd0, err}, 32'd0);
        chk("st_b_rdcnt", rd_cnt, 32'd1);
        chk("st_b_rdaddr", rd_addr, 32'h0000_0300);
        chk("st_b_wrcnt", wr_cnt, 32'd1);
        chk("st_b_wraddr", wr_addr, 32'h0000_0300);
        chk("st_b_wrdata", wr_data, 32'h1122_AA44);
        chk("st_b_cyccnt", cyc_cnt, 32'd2);

        // Half store via RMW
        mem_word = 32'hAABB_CCDD;
        run_req("st_h", 1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'hFFFF_5678, 20, lat, rdata, err);
        chk("st_h_wrdata", wr_data, 32'h5678_CCDD);
        chk("st_h_wraddr", wr_addr, 32'h0000_0000);

        // Word store, one wait state
        waits = 1;
        run_req("st_w", 1'b1, 2'd2, 1'b0, 32'h0000_0500, 32'hDEAD_BEEF, 20, lat, rdata, err);
        chk("st_w_lat", lat, 32'd3);
        chk("st_w_rdcnt", rd_cnt, 32'd0);
        chk("st_w_wrcnt", wr_cnt, 32'd1);
        chk("st_w_wrdata", wr_data, 32'hDEAD_BEEF);
        chk("st_w_wraddr", wr_addr, 32'h0000_0500);

        // Misaligned accesses
        waits = 0;
        run_req("mis_w", 1'b1, 2'd2, 1'b0, 32'h0000_0402, 32'h1111_2222, 20, lat, rdata, err);
        chk("mis_w_lat", lat, 32'd1);
        chk("mis_w_err", {31'd0, err}, 32'd1);
        chk("mis_w_rdata", rdata, 32'd0);
        chk("mis_w_cyccnt", cyc_cnt, 32'd0);
        run_req("mis_h", 1'b0, 2'd1, 1'b0, 32'h0000_0011, 32'h0, 20, lat, rdata, err);
        chk("mis_h_err", {31'd0, err}, 32'd1);
        chk("mis_h_lat", lat, 32'd1);

        // Stray ack while idle is ignored
        clear_mon();
        force_ack = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen = seen | dmem_bus.dmem_gnt_o | wb_bus.data_mem_cyc_o;
        end
        force_ack = 1'b0;
        chk("stray_ack", {31'd0, seen}, 32'd0);

        // Reset during a word write after 2 wait cycles
        clear_mon();
        waits = 10;
        dmem_bus.dmem_wren_i  = 1'b1;
        dmem_bus.dmem_size_i  = 2'd2;
        dmem_bus.dmem_addr_i  = 32'h0000_0600;
        dmem_bus.dmem_wdata_i = 32'h55AA_55AA;
        dmem_bus.dmem_req_i   = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (wb_bus.data_mem_cyc_o === 1'b1) break;
        end
        chk("rst_mid_cyc_up", {31'd0, wb_bus.data_mem_cyc_o}, 32'd1);
        chk("rst_mid_we_up", {31'd0, wb_bus.data_mem_we_o}, 32'd1);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        dmem_bus.dmem_req_i = 1'b0;
        #1;
        chk("rst_mid_cyc", {31'd0, wb_bus.data_mem_cyc_o}, 32'd0);
        chk("rst_mid_we", {31'd0, wb_bus.data_mem_we_o}, 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen = seen | dmem_bus.dmem_gnt_o;
        end
        chk("rst_mid_no_gnt", {31'd0, seen}, 32'd0);
        chk("rst_mid_no_wr", wr_cnt, 32'd0);
        $display("txn rst_mid: reset asserted during write, gnt_seen=%0b writes=%0d", seen, wr_cnt);

        waits = 0;
        mem_word = 32'hCAFE_F00D;
        run_req("post_rst", 1'b0, 2'd2, 1'b0, 32'h0000_0700, 32'h0, 20, lat, rdata, err);
        chk("post_rst_lat", lat, 32'd2);
        chk("post_rst_rdata", rdata, 32'hCAFE_F00D);
        chk("post_rst_err", {31'd0, err}, 32'd0);

`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
        // Slave never acks: abort after 8 cycles with err
        waits = 100000;
        run_req("tmo_ld", 1'b0, 2'd2, 1'b0, 32'h0000_0800, 32'h0, 40, lat, rdata, err);
        chk("tmo_ld_lat", lat, 32'd9);
        chk("tmo_ld_err", {31'd0, err}, 32'd1);
        chk("tmo_ld_rdata", rdata, 32'd0);
        chk("tmo_ld_cyccnt", cyc_cnt, 32'd8);
        run_req("tmo_rmw", 1'b1, 2'd0, 1'b0, 32'h0000_0801, 32'h0000_00FF, 40, lat, rdata, err);
        chk("tmo_rmw_err", {31'd0, err}, 32'd1);
        chk("tmo_rmw_wrcnt", wr_cnt, 32'd0);
        chk("tmo_rmw_cyccnt", cyc_cnt, 32'd8);
`endif

        chk("bus_stable", unstable_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/harv_dmem_wb_bridge.md
Name: harv_dmem_wb_bridge

Overview:
- Sits between the harv core's data-memory port and the Controller's second (data) Wishbone-style bus.
- Converts the core's req/gnt transaction into a classic cyc/stb/we/ack cycle.
- The downstream bus is word-only, with no byte selects, so sub-word stores are done as read-modify-write.
- Sub-word loads are lane-extracted and sign- or zero-extended.

Parameters:
- TIMEOUT_CYCLES, 1024: bus cycles to wait for ack before aborting. Used only with the optional feature.

Ports:
- clk_core  in  1  core clock
- rst_core  in  1  reset, asynchronous, active-high
- dmem_req_i  in  1  core request; fields held stable until gnt
- dmem_wren_i  in  1  1 = store, 0 = load
- dmem_size_i  in  2  access size: 0 byte, 1 half, 2 word; 3 reserved, treated as word
- dmem_usgn_i  in  1  load zero-extend when 1
- dmem_addr_i  in  32  byte address
- dmem_wdata_i  in  32  store data, right-aligned
- dmem_gnt_o  out  1  one-cycle completion pulse
- dmem_err_o  out  1  valid with gnt: misaligned access or timeout
- dmem_rdata_o  out  32  load result, valid with gnt
- data_mem_cyc_o  out  1  bus cycle active
- data_mem_stb_o  out  1  equal to cyc
- data_mem_we_o  out  1  bus write
- data_mem_addr_o  out  32  word address {addr[31:2], 2'b00}
- data_mem_data_o  out  32  bus write data
- data_mem_data_i  in  32  bus read data
- data_mem_ack_i  in  1  bus acknowledge; only meaningful while cyc=1

Behaviour:
- Reset values: all outputs 0; state IDLE.
  - Reset is asynchronous: cyc drops immediately, even mid-cycle.
  - No gnt is issued for an aborted transaction.
- All outputs are registered.
- Request fields are captured in IDLE when req=1.
- FSM states: IDLE, READ, MERGE, WRITE, RESP.
- IDLE, req=1:
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0): go to RESP with err=1, rdata=0, no bus activity.
  - Load: go to READ.
  - Word store: go to WRITE with data_o=wdata.
  - Byte/half store: go to READ (RMW).
- READ: cyc=1, we=0; hold until ack.
  - On ack, a load latches the extracted/extended lane into rdata and goes to RESP.
  - On ack, an RMW store latches the read word and goes to MERGE.
- MERGE: one cycle with cyc=0.
  - Replace lane addr[1:0] (byte) or addr[1] (half) with the low bits of wdata.
  - Go to WRITE.
- WRITE: cyc=1, we=1; hold until ack, then go to RESP.
- RESP: gnt=1 for exactly one cycle, err as computed, then IDLE.
  - req seen during RESP is ignored; the next request is sampled in IDLE.
- cyc/stb/we/addr/data stay stable for the whole bus cycle and deassert in the cycle after ack.
- Latency with a zero-wait slave (ack in the first cyc cycle), counted from the req-sample edge:
  - load: gnt 2 cycles later
  - word store: gnt 2 cycles later
  - sub-word store: gnt 4 cycles later
  - misaligned: gnt 1 cycle later
- Lane extraction:
  - byte = word[8*addr[1:0] +: 8]; half = word[16*addr[1] +: 16].
  - Sign-extend unless usgn=1. Word loads ignore usgn.
- An ack arriving while cyc=0 is ignored.
- The RMW is not atomic with respect to other bus masters; this is accepted, since the core is the single master.

Optional Feature:
- Macro: HARV_DMEM_BRIDGE_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to READ/WRITE and increments each cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 without ack: drop cyc next cycle and go to RESP with err=1, rdata=0.
  - An RMW whose read times out never writes.
- Undefined: no counter; the bridge waits indefinitely for ack.

Decomposition:
- Package harv_dmem_bridge_pkg holds:
  - typedef enum for access size (SIZE_BYTE, SIZE_HALF, SIZE_WORD)
  - typedef enum for FSM state
  - function is_misaligned(size, addr)
  - function extract_lane(word, size, addr_lo, usgn)
  - function merge_lane(old, wdata, size, addr_lo)
- One sub-module is natural: harv_dmem_lane_unit, a combinational extract/merge wrapper around the package functions. This keeps the FSM file purely sequential.

Test Plan:
- Signed byte load: addr 0x103, usgn=0; slave returns 0x80FF_1234, ack on first cycle -> one read at 0x100, gnt 2 cycles after req, rdata 0xFFFF_FF80, err=0.
- Unsigned half load: addr 0x202, usgn=1; slave returns 0xBEEF_0000 with 3 wait states -> rdata 0x0000_BEEF, gnt after ack+1, cyc stable throughout.
- Byte store RMW: addr 0x301, wdata 0xAA; memory word 0x1122_3344 -> read 0x300, then write 0x1122_AA44 to 0x300 with we=1; one gnt, err=0.
- Misaligned word store: addr 0x402 -> no cyc ever asserted, gnt+err one cycle after req.
- Reset during WRITE, after 2 wait cycles: cyc/we fall asynchronously; no gnt; next load after reset completes normally.
- With HARV_DMEM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=8: slave never acks a load -> cyc deasserts after 8 cycles, gnt with err=1, rdata 0.
